// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl -- initiator side of the CPU memory interface.
//
// Takes single-word or burst (1..2**LEN_W words) read/write requests from the
// datapath and drives the 512x32 RAM pins (Read/Write/Address/Mdatain). The
// RAM has a one-cycle registered read, so every read word costs an issue cycle
// (Read=1) plus a capture cycle (data_output sampled). Write words are pulled
// from the datapath one at a time through a wr_valid/wr_ready handshake.
//
// Ports:
//   Clock, Clear          rising-edge clock, synchronous active-low reset
//   req_*                 request channel (accepted on req_valid && req_ready)
//   wr_data/valid/ready   write-word channel from the MDR
//   rd_data/rd_valid      captured read word, one-cycle valid pulse
//   done                  one-cycle pulse at the end of each request
//   Read/Write/Address/Mdatain, data_output   RAM interface
module mem_access_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              Read,
    output logic              Write,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Mdatain,
    input  logic [DATA_W-1:0] data_output
);

    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_CAPT, WR_WAIT, WR_ISSUE, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;        // address of the current word
    logic [LEN_W-1:0]    cnt_q, cnt_d;          // words remaining minus one
    logic [ADDR_W-1:0]   address_q, address_d;  // RAM address pins
    logic [DATA_W-1:0]   mdatain_q, mdatain_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            address_q  <= '0;
            mdatain_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            address_q  <= address_d;
            mdatain_q  <= mdatain_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // The Address pins are loaded only on entry to an issue state, so they
    // hold their last value while Read and Write are both low.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        address_d  = address_q;
        mdatain_d  = mdatain_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    cnt_d  = req_len;
                    if (req_write) begin
                        state_d = WR_WAIT;
                    end else begin
                        address_d = req_addr;
                        state_d   = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: state_d = RD_CAPT;
            RD_CAPT: begin
                // RAM output is valid this cycle; the pulse shows next cycle,
                // which for the last word lines up with done.
                rd_data_d  = data_output;
                rd_valid_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d     = cnt_q - 1'b1;
                    addr_d    = addr_q + 1'b1;
                    address_d = addr_q + 1'b1;
                    state_d   = RD_ISSUE;
                end
            end
            WR_WAIT: begin
                if (wr_valid) begin
                    mdatain_d = wr_data;
                    address_d = addr_q;
                    state_d   = WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    addr_d  = addr_q + 1'b1;
                    state_d = WR_WAIT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All outputs come from registered state only.
    assign req_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == WR_WAIT);
    assign Read      = (state_q == RD_ISSUE);
    assign Write     = (state_q == WR_ISSUE);
    assign done      = (state_q == DONE);
    assign Address   = address_q;
    assign Mdatain   = mdatain_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the CPU memory interface: the master that drives the 512 x 32 RAM's Read/Write/Address/Mdatain pins and collects its registered data_output.
- Accepts single-word or burst (1-16 word) read/write requests from the datapath/control unit.
- Sequences them to the RAM's one-cycle registered-read timing.
- Returns read data and a completion pulse.

Parameters:
- ADDR_W, 9, RAM address width (512 words).
- DATA_W, 32, word width.
- LEN_W, 4, burst length field width; words transferred = req_len + 1.

Ports:
- Clock  input  1  rising-edge system clock
- Clear  input  1  synchronous active-low reset
- req_valid  input  1  request strobe; accepted when req_valid && req_ready
- req_ready  output  1  high only in IDLE
- req_write  input  1  1 = write burst, 0 = read burst
- req_addr  input  ADDR_W  start word address
- req_len  input  LEN_W  words minus one
- wr_data  input  DATA_W  write word from datapath (MDR)
- wr_valid  input  1  wr_data valid
- wr_ready  output  1  controller ready to take a write word
- rd_data  output  DATA_W  captured read word
- rd_valid  output  1  one-cycle pulse, rd_data valid
- done  output  1  one-cycle pulse at end of request
- Read  output  1  to RAM
- Write  output  1  to RAM
- Address  output  ADDR_W  to RAM
- Mdatain  output  DATA_W  to RAM
- data_output  input  DATA_W  from RAM (registered, valid the cycle after a Read edge)

Behaviour:
- Reset: Clear sampled low at a rising edge forces the following:
  - state=IDLE.
  - Read=Write=0, rd_valid=done=0, rd_data=0, Address=0, Mdatain=0.
  - Internal address/count registers cleared.
  - Reset mid-burst aborts immediately: no done and no further Read/Write.
- All outputs are registered or decoded from registered state only; no combinational path from any input to Read/Write/Address.
- Read and Write are never high in the same cycle.
- States: IDLE, RD_ISSUE, RD_CAPT, WR_WAIT, WR_ISSUE, DONE.
- IDLE:
  - req_ready=1.
  - On accept: addr<=req_addr, cnt<=req_len, dir<=req_write.
  - Next state is WR_WAIT if req_write, else RD_ISSUE.
- RD_ISSUE:
  - Read=1, Address=addr, for exactly one cycle.
  - Next state RD_CAPT.
- RD_CAPT:
  - Read=0.
  - At the closing edge: rd_data<=data_output and rd_valid<=1, so the pulse is seen in the next cycle.
  - If cnt==0 go to DONE; else cnt<=cnt-1, addr<=addr+1 (mod 2^ADDR_W, so 511 wraps to 0), go to RD_ISSUE.
  - Read throughput is 1 word / 2 cycles.
  - Read latency from accept edge to rd_valid high is 3 cycles.
  - rd_valid has no backpressure; the consumer must take it.
- WR_WAIT:
  - wr_ready=1.
  - When wr_valid: Mdatain<=wr_data, go to WR_ISSUE.
  - Stalls indefinitely without wr_valid; Read=Write=0 while stalled.
- WR_ISSUE:
  - Write=1, Address=addr, Mdatain stable, wr_ready=0, for exactly one cycle.
  - Then, if cnt==0 go to DONE; else decrement cnt, increment addr (wrapping), go to WR_WAIT.
- DONE:
  - done=1 for one cycle; then IDLE.
  - For reads, the final rd_valid pulse coincides with done.
- Address holds its last value whenever Read=Write=0.
- Requests presented outside IDLE are ignored (req_ready=0).
- wr_valid outside WR_WAIT is ignored.
- req_len=0 means a single word; req_len=15 means 16 words.

Test Plan:
- Reset: hold Clear=0 for 2 edges with req_valid=1 -> Read=Write=0, req_ready=1 after release, rd_valid=done=0.
- Single write then read: write addr 9'h005, len 0, wr_data 32'hDEADBEEF -> one cycle Write=1 with Address=5 and Mdatain=DEADBEEF, done. Then read addr 5, len 0 -> Read=1 one cycle, rd_valid with rd_data=DEADBEEF 3 cycles after accept, done same cycle.
- Burst wrap: write len 3 at addr 510 with data 1, 2, 3, 4 -> Write at addresses 510, 511, 0, 1. Read back len 3 at addr 510 -> rd_data 1, 2, 3, 4 in order, 4 rd_valid pulses 2 cycles apart, one done.
- Write stall: write len 1 and withhold wr_valid 5 cycles before each word -> wr_ready stays high while stalled, no Write pulses during the stall, exactly 2 Write pulses total, done after the second.
- Busy rejection: assert req_valid with a new request during a read burst -> req_ready=0 and the request is not executed. Present it again once in IDLE -> it is accepted.
- Reset mid-burst: drive Clear=0 during WR_ISSUE of word 2 of a 4-word write -> Write=0 from the next cycle, no done, back to IDLE, next request executes normally.
